iir_inverse: RTL and testbench
==============================

// Module: iir_inverse
// PURPOSE
//   Inverse (equalizer) of the first-order IIR filter y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1].
//   Consumes the filter's y stream and reconstructs x[n] = (y[n] - b1*x[n-1] - a1*y[n-1]) / b0.
//   Uses a multi-cycle restoring divider and valid/ready handshakes on both sides.
//   Sits downstream of the IIR datapath for loop-back self-check and channel equalization.
// PARAMETERS
//   XW  4  width of reconstructed sample x_hat (signed)
//   CW  4  width of coefficients b0, b1, a1 (signed)
//   YW  8  width of filter output sample y_in (signed)
//   (localparam NW = YW+CW: numerator width, signed, and the number of divider iterations; 12 by default)
// PORTS
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   y_in and coefficients are valid
//   in_ready   out  1   block can accept a sample (high only in IDLE)
//   y_in       in   YW  filter output sample, signed
//   b0         in   CW  feed-forward coefficient for x[n], signed; sampled on accept
//   b1         in   CW  feed-forward coefficient for x[n-1], signed; sampled on accept
//   a1         in   CW  feedback coefficient for y[n-1], signed; sampled on accept
//   out_valid  out  1   x_hat and flags are valid
//   out_ready  in   1   consumer accepts the result
//   x_hat      out  XW  reconstructed sample, signed
//   err_b0z    out  1   b0 was 0; x_hat forced to 0
//   sat        out  1   quotient was clipped to the XW signed range
//   inexact    out  1   division remainder was non-zero
// BEHAVIOUR
//   Reset (sync, high): state=IDLE; x_prev=0; y_prev=0; x_hat=0; out_valid=0; all flags=0.
//     Reset wins over every other event, including reset in the middle of an operation.
//   FSM states: IDLE -> CALC -> DIV -> FIX -> DONE -> IDLE.
//   IDLE:
//     in_ready=1.
//     On in_valid: latch y_in, b0, b1, a1 and go to CALC.
//   CALC (1 cycle):
//     num = y - b1*x_prev - a1*y_prev, sign-extended to NW bits. This never overflows (|num| <= 1216).
//     If b0==0: go to FIX with err_b0z set.
//     Otherwise: take magnitudes of num and b0, record the quotient sign, clear the counter, go to DIV.
//   DIV (exactly NW cycles):
//     Restoring division, one quotient bit per cycle, MSB first.
//     Leaves |num|/|b0| (truncated) and the remainder.
//   FIX (1 cycle):
//     Apply the sign: quotient is truncated toward zero.
//     Saturate to [-2^(XW-1), 2^(XW-1)-1] and set sat on clipping.
//     inexact = (remainder != 0).
//     Update history: x_prev <= x_hat (after saturation; 0 on err); y_prev <= latched y.
//   DONE:
//     out_valid=1. x_hat and flags are held stable until out_ready.
//     On out_ready: out_valid drops on the next edge; go to IDLE.
//   Latency:
//     Accept at edge k -> out_valid high after edge k+NW+2 (14 cycles by default).
//     When b0==0 -> out_valid high after edge k+2.
//   Throughput: one sample per NW+4 cycles at best; in_ready=0 in every state except IDLE.
//   Flags and x_hat update only in FIX; each flag is cleared in FIX when its condition is absent.
//   History is not cleared by err_b0z or by saturation; only reset clears it.
// TESTING
//   1. Reset, b0=3, b1=0, a1=1, y_in=15,30,45 -> x_hat=5,5,5; all flags 0; each out_valid 14 cycles after its accept.
//   2. Reset, b0=2, b1=-2, a1=-4, y_in=10 then -40 -> x_hat=5 then 5.
//   3. History 0, b0=1, y_in=100 -> x_hat=7, sat=1. Then b0=1, b1=0, a1=0, y_in=-100 -> x_hat=-8, sat=1.
//   4. History 0, b0=2: y_in=7 -> x_hat=3, inexact=1; then a1=0, b1=0, y_in=-7 -> x_hat=-3, inexact=1.
//   5. b0=0, y_in=20 -> x_hat=0, err_b0z=1, out_valid 2 cycles after accept; next sample uses x_prev=0.
//   6. Backpressure and reset:
//      - Hold out_ready=0 for 5 cycles in DONE -> x_hat and flags stable, in_ready=0.
//      - Assert reset during DIV -> next edge IDLE, outputs 0, history cleared.

Source files
------------

// File: rtl/iir_inverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : iir_inverse                                                      |
// | Inverse of a first-order IIR: rebuilds x[n] from y[n] via restoring divide.|
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module iir_inverse #(
  parameter int XW = 4,
  parameter int CW = 4,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [YW-1:0] y_in,
  input  logic [CW-1:0] b0,
  input  logic [CW-1:0] b1,
  input  logic [CW-1:0] a1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] x_hat,
  output logic          err_b0z,
  output logic          sat,
  output logic          inexact
);

  localparam int NW   = YW + CW;
  localparam int CNTW = $clog2(NW);
  localparam logic [NW-1:0] POS_LIM = NW'(2 ** (XW - 1) - 1);
  localparam logic [NW-1:0] NEG_LIM = NW'(2 ** (XW - 1));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic signed [YW-1:0] y_lat, y_prev;
  logic signed [CW-1:0] b0_lat, b1_lat, a1_lat;
  logic signed [XW-1:0] x_prev;
  logic [NW-1:0]        dvd;      // dividend shifts out MSB-first, quotient shifts in
  logic [CW-1:0]        den;
  logic [CW:0]          rem;
  logic                 q_neg;
  logic                 div_err;
  logic [CNTW-1:0]      cnt;

  logic signed [CW+XW-1:0] p_b1;
  logic signed [NW-1:0]    p_a1;
  logic signed [NW-1:0]    num;
  logic [NW-1:0]           num_u, num_mag;
  logic [CW-1:0]           b0_u, b0_mag;
  logic [CW:0]             trial, diff;
  logic                    take;
  logic [XW-1:0]           q_low;
  logic signed [XW-1:0]    x_fix;
  logic                    sat_fix;

  assign p_b1    = (CW+XW)'(b1_lat) * (CW+XW)'(x_prev);
  assign p_a1    = NW'(a1_lat) * NW'(y_prev);
  assign num     = NW'(y_lat) - NW'(p_b1) - p_a1;
  assign num_u   = num;
  assign num_mag = num_u[NW-1] ? -num_u : num_u;
  assign b0_u    = b0_lat;
  assign b0_mag  = b0_u[CW-1] ? -b0_u : b0_u;

  // rem < den <= 2^(CW-1), so the shifted-in trial always fits in CW+1 bits
  assign trial = {rem[CW-1:0], dvd[NW-1]};
  assign take  = (trial >= {1'b0, den});
  assign diff  = trial - {1'b0, den};
  assign q_low = dvd[XW-1:0];

  always_comb begin
    x_fix   = '0;
    sat_fix = 1'b0;
    if (div_err) begin
      x_fix = '0;
    end else if (!q_neg && (dvd > POS_LIM)) begin
      x_fix   = {1'b0, {(XW-1){1'b1}}};
      sat_fix = 1'b1;
    end else if (q_neg && (dvd > NEG_LIM)) begin
      x_fix   = {1'b1, {(XW-1){1'b0}}};
      sat_fix = 1'b1;
    end else begin
      x_fix = q_neg ? -q_low : q_low;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    state_nxt = (b0_lat == '0) ? FIX : DIV;
      DIV:     if (cnt == CNTW'(NW - 1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      y_lat   <= '0;
      b0_lat  <= '0;
      b1_lat  <= '0;
      a1_lat  <= '0;
      x_prev  <= '0;
      y_prev  <= '0;
      dvd     <= '0;
      den     <= '0;
      rem     <= '0;
      q_neg   <= 1'b0;
      div_err <= 1'b0;
      cnt     <= '0;
      x_hat   <= '0;
      err_b0z <= 1'b0;
      sat     <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          y_lat  <= y_in;
          b0_lat <= b0;
          b1_lat <= b1;
          a1_lat <= a1;
        end
        CALC: begin
          div_err <= (b0_lat == '0);
          dvd     <= num_mag;
          den     <= b0_mag;
          rem     <= '0;
          q_neg   <= num[NW-1] ^ b0_lat[CW-1];
          cnt     <= '0;
        end
        DIV: begin
          dvd <= {dvd[NW-2:0], take};
          rem <= take ? diff : trial;
          cnt <= cnt + CNTW'(1);
        end
        FIX: begin
          x_hat   <= x_fix;
          err_b0z <= div_err;
          sat     <= sat_fix;
          inexact <= !div_err && (rem != '0);
          x_prev  <= x_fix;
          y_prev  <= y_lat;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iir_inverse.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_iir_inverse                                                   |
// | Directed self-checking bench for iir_inverse.                              |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_iir_inverse;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y_in;
  logic [3:0] b0, b1, a1;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] x_hat;
  logic       err_b0z, sat, inexact;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  iir_inverse dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y_in     (y_in),
    .b0       (b0),
    .b1       (b1),
    .a1       (a1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_hat    (x_hat),
    .err_b0z  (err_b0z),
    .sat      (sat),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input string tag, input int y, input int b0v, input int b1v,
                     input int a1v, input int ex, input int eerr, input int esat,
                     input int einx, input int elat, input int hold);
    int lat;
    @(negedge clk);
    y_in     = y[7:0];
    b0       = b0v[3:0];
    b1       = b1v[3:0];
    a1       = a1v[3:0];
    in_valid = 1'b1;
    check({tag, " in_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " x_hat"}, int'($signed(x_hat)), ex);
    check({tag, " flags"}, int'({err_b0z, sat, inexact}), (eerr << 2) | (esat << 1) | einx);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold x_hat"}, int'($signed(x_hat)), ex);
      check({tag, " hold sat"}, int'(sat), esat);
      check({tag, " hold hs"}, int'({out_valid, in_ready}), 2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " release"}, int'({out_valid, in_ready}), 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y_in      = '0;
    b0        = '0;
    b1        = '0;
    a1        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset hs", int'({out_valid, in_ready}), 1);
    check("reset x_hat", int'(x_hat), 0);
    check("reset flags", int'({err_b0z, sat, inexact}), 0);

    // Test 1: steady 5s through the a1 feedback path
    run("t1a", 15, 3, 0, 1, 5, 0, 0, 0, 14, 0);
    run("t1b", 30, 3, 0, 1, 5, 0, 0, 0, 14, 0);
    run("t1c", 45, 3, 0, 1, 5, 0, 0, 0, 14, 0);

    // Test 2: negative b1/a1 with history
    do_reset();
    run("t2a", 10, 2, -2, -4, 5, 0, 0, 0, 14, 0);
    run("t2b", -40, 2, -2, -4, 5, 0, 0, 0, 14, 0);

    // Test 3: saturation both directions
    do_reset();
    run("t3a", 100, 1, 0, 0, 7, 0, 1, 0, 14, 0);
    run("t3b", -100, 1, 0, 0, -8, 0, 1, 0, 14, 0);

    // Test 4: truncation toward zero with remainder
    run("t4a", 7, 2, 0, 0, 3, 0, 0, 1, 14, 0);
    run("t4b", -7, 2, 0, 0, -3, 0, 0, 1, 14, 0);

    // Test 5: b0 = 0 forces zero and resets x_prev for the next sample
    run("t5a", 20, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    run("t5b", 3, 1, 1, 0, 3, 0, 0, 0, 14, 0);

    // Test 6: backpressure, then reset mid-division
    run("t6hold", 100, 1, 0, 0, 7, 0, 1, 0, 14, 5);
    @(negedge clk);
    y_in     = 8'd50;
    b0       = 4'd1;
    b1       = 4'd0;
    a1       = 4'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6rst hs", int'({out_valid, in_ready}), 1);
    check("t6rst x_hat", int'(x_hat), 0);
    check("t6rst flags", int'({err_b0z, sat, inexact}), 0);
    @(negedge clk);
    reset = 1'b0;
    run("t6post", 5, 1, 1, 1, 5, 0, 0, 0, 14, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
